// File: rtl/instr_fetch_unit_if.sv
// Memory read bus between the fetch unit (master) and instruction memory (slave).
interface instr_fetch_unit_if #(
  parameter int WORD_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 5
);
  logic                     mem_rd;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0]    mem_rdata;
  logic                     mem_ready;

  modport master (output mem_rd, output mem_addr, input mem_rdata, input mem_ready);
  modport slave  (input mem_rd, input mem_addr, output mem_rdata, output mem_ready);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE -> REQ -> WAIT sequencer that reads one word at
// pc, splits it into opcode/operand, advances pc or takes a pending jump.
// Optional feature: define FETCH_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles and pulse fetch_fault.
module instr_fetch_unit #(
  parameter int WORD_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 5,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic                                fetch,
  input  logic                                pc_load,
  input  logic [ADDRESS_WIDTH-1:0]            pc_load_val,
  instr_fetch_unit_if.master                  mem,
  output logic [WORD_WIDTH-ADDRESS_WIDTH-1:0] instr,
  output logic [ADDRESS_WIDTH-1:0]            operand,
  output logic [ADDRESS_WIDTH-1:0]            pc,
  output logic                                ir_valid,
  output logic                                busy
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic                                fetch_fault
`endif
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [WORD_WIDTH-1:0]    ir_q, ir_d;
  logic                     ir_valid_q, ir_valid_d;
  logic                     pend_vld_q, pend_vld_d;
  logic [ADDRESS_WIDTH-1:0] pend_val_q, pend_val_d;
  logic                     done;
  logic                     tmo;

  assign done = (state_q == S_WAIT) && mem.mem_ready;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             fault_q;

  // Timeout fires on the TIMEOUT_CYCLES-th consecutive WAIT cycle without data.
  assign tmo = (state_q == S_WAIT) && !mem.mem_ready &&
               (tcnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // WAIT-cycle counter, cleared whenever the unit is not waiting.
  always_comb begin
    tcnt_d = '0;
    if ((state_q == S_WAIT) && !done && !tmo) begin
      tcnt_d = tcnt_q + 1'b1;
    end
  end

  // Timeout counter and one-cycle fault pulse.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tcnt_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      fault_q <= tmo;
    end
  end

  assign fetch_fault = fault_q;
`else
  assign tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; fetch is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fetch) state_d = S_REQ;
      S_REQ:   state_d = S_WAIT;
      S_WAIT:  if (mem.mem_ready || tmo) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    mem.mem_rd = 1'b0;
    busy       = 1'b0;
    case (state_q)
      S_REQ, S_WAIT: begin
        mem.mem_rd = 1'b1;
        busy       = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next values: pc stays frozen while busy so mem_addr is stable;
  // jumps requested while busy are parked and applied at completion.
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    pend_vld_d = pend_vld_q;
    pend_val_d = pend_val_q;
    if (state_q == S_IDLE) begin
      if (pc_load) pc_d = pc_load_val;
    end else if (done) begin
      ir_d       = mem.mem_rdata;
      ir_valid_d = 1'b1;
      pend_vld_d = 1'b0;
      if (pc_load)         pc_d = pc_load_val;
      else if (pend_vld_q) pc_d = pend_val_q;
      else                 pc_d = pc_q + 1'b1;
    end else if (tmo) begin
      pend_vld_d = 1'b0;
    end else if (pc_load) begin
      pend_vld_d = 1'b1;
      pend_val_d = pc_load_val;
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc_q       <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_val_q <= '0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      pend_vld_q <= pend_vld_d;
      pend_val_q <= pend_val_d;
    end
  end

  assign mem.mem_addr = pc_q;
  assign instr        = ir_q[WORD_WIDTH-1:ADDRESS_WIDTH];
  assign operand      = ir_q[ADDRESS_WIDTH-1:0];
  assign pc           = pc_q;
  assign ir_valid     = ir_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus pushes expected read
// addresses and IR/pc results; a negedge monitor pops and compares them.
module tb_instr_fetch_unit;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       fetch;
  logic       pc_load;
  logic [4:0] pc_load_val;
  logic [2:0] instr;
  logic [4:0] operand;
  logic [4:0] pc;
  logic       ir_valid;
  logic       busy;
`ifdef FETCH_TIMEOUT_EN
  logic       fetch_fault;
`endif

  int total = 0;
  int bad   = 0;
  int ir_seen = 0;
  int n_ir_exp = 0;
  logic [4:0]  pc_m = 5'd0;
  logic [4:0]  exp_addr_q[$];
  logic [12:0] exp_ir_q[$];
  logic        rd_prev = 1'b0;

  instr_fetch_unit_if #(.WORD_WIDTH(8), .ADDRESS_WIDTH(5)) m ();

  instr_fetch_unit #(
    .WORD_WIDTH(8),
    .ADDRESS_WIDTH(5),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .fetch(fetch),
    .pc_load(pc_load),
    .pc_load_val(pc_load_val),
    .mem(m),
    .instr(instr),
    .operand(operand),
    .pc(pc),
    .ir_valid(ir_valid),
    .busy(busy)
`ifdef FETCH_TIMEOUT_EN
    ,
    .fetch_fault(fetch_fault)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every new read and every ir_valid pulse is matched against the queues.
  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      if (m.mem_rd && !rd_prev) begin
        if (exp_addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_read: got addr=%0h want no read", m.mem_addr);
        end else begin
          chk("read_addr", 32'(m.mem_addr), 32'(exp_addr_q.pop_front()));
        end
      end
      if (ir_valid) begin
        ir_seen++;
        if (exp_ir_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ir_valid: got ir=%0h pc=%0h want no pulse",
                   {instr, operand}, pc);
        end else begin
          chk("ir_and_pc", 32'({instr, operand, pc}), 32'(exp_ir_q.pop_front()));
        end
      end
    end
    rd_prev = m.mem_rd;
  end

  // One fetch transaction. il/iv: jump applied together with fetch in IDLE.
  // nld jumps issued during WAIT (cycle 0 -> jv1, cycle 1 -> jv2).
  // hold keeps fetch asserted while busy.
  task automatic fetch_op(input logic [7:0] rdata, input int unsigned delay,
                          input logic il, input logic [4:0] iv,
                          input int unsigned nld, input logic [4:0] jv1,
                          input logic [4:0] jv2, input logic hold);
    logic [4:0] addr;
    logic [4:0] nxt;
    if (il) pc_m = iv;
    addr = pc_m;
    nxt  = (nld == 2) ? jv2 : (nld == 1) ? jv1 : addr + 5'd1;
    exp_addr_q.push_back(addr);
    exp_ir_q.push_back({rdata, nxt});
    n_ir_exp++;
    fetch = 1'b1; pc_load = il; pc_load_val = iv; m.mem_rdata = rdata;
    @(posedge CLK); #1;
    fetch = hold; pc_load = 1'b0;
    chk("req_mem_rd", 32'(m.mem_rd), 32'd1);
    chk("req_busy", 32'(busy), 32'd1);
    @(posedge CLK); #1;
    for (int unsigned k = 0; k <= delay; k++) begin
      pc_load     = ((k == 0) && (nld >= 1)) || ((k == 1) && (nld >= 2));
      pc_load_val = (k == 0) ? jv1 : jv2;
      m.mem_ready = (k == delay);
      chk("wait_addr_hold", 32'(m.mem_addr), 32'(addr));
      chk("wait_no_ir_valid", 32'(ir_valid), 32'd0);
      @(posedge CLK); #1;
    end
    fetch = 1'b0; pc_load = 1'b0; m.mem_ready = 1'b0;
    chk("ir_valid_latency", 32'(ir_valid), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    @(posedge CLK); #1;
    chk("ir_valid_one_cycle", 32'(ir_valid), 32'd0);
    chk("idle_mem_rd", 32'(m.mem_rd), 32'd0);
    chk("pc_after", 32'(pc), 32'(nxt));
    pc_m = nxt;
  endtask

  initial begin
    RST_N = 1'b0; fetch = 1'b0; pc_load = 1'b0; pc_load_val = 5'd0;
    m.mem_rdata = 8'h00; m.mem_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", 32'({instr, operand}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_rd", 32'(m.mem_rd), 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Basic fetch at 0: A7 -> instr 5, operand 07, pc 1, minimum latency.
    fetch_op(8'hA7, 0, 1'b0, 5'd0, 0, 5'd0, 5'd0, 1'b0);
    chk("hold_instr", 32'(instr), 32'h5);
    chk("hold_operand", 32'(operand), 32'h07);

    // Jump to 1F together with fetch; pc wraps to 0.
    fetch_op(8'h3C, 0, 1'b1, 5'h1F, 0, 5'd0, 5'd0, 1'b0);

    // Jump during WAIT with ready delayed 4 cycles: pc takes 0A.
    fetch_op(8'h5E, 4, 1'b0, 5'd0, 1, 5'h0A, 5'd0, 1'b0);

    // Second jump while busy overwrites the first.
    fetch_op(8'hC1, 3, 1'b0, 5'd0, 2, 5'h03, 5'h12, 1'b0);

    // fetch held high while busy: exactly one read and one ir_valid.
    fetch_op(8'h88, 2, 1'b0, 5'd0, 0, 5'd0, 5'd0, 1'b1);

    // Jump in IDLE without fetch.
    pc_load = 1'b1; pc_load_val = 5'h1E;
    @(posedge CLK); #1;
    pc_load = 1'b0;
    chk("idle_load_pc", 32'(pc), 32'h1E);
    chk("idle_load_busy", 32'(busy), 32'd0);
    pc_m = 5'h1E;
    fetch_op(8'hFF, 1, 1'b0, 5'd0, 0, 5'd0, 5'd0, 1'b0);

    // Reset during WAIT, then a late mem_ready must be ignored.
    exp_addr_q.push_back(pc_m);
    fetch = 1'b1; m.mem_rdata = 8'hFF;
    @(posedge CLK); #1;
    fetch = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1; m.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("post_rst_no_ir_valid", 32'(ir_valid), 32'd0);
    end
    m.mem_ready = 1'b0;
    chk("post_rst_ir", 32'({instr, operand}), 32'd0);
    chk("post_rst_pc", 32'(pc), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    pc_m = 5'd0;

    // Normal operation resumes from address 0.
    fetch_op(8'h42, 0, 1'b0, 5'd0, 0, 5'd0, 5'd0, 1'b0);

`ifdef FETCH_TIMEOUT_EN
    begin
      int n;
      logic seen;
      n = 0; seen = 1'b0;
      exp_addr_q.push_back(pc_m);
      fetch = 1'b1;
      while (n < 40 && !seen) begin
        @(posedge CLK); #1;
        fetch = 1'b0;
        n++;
        seen = fetch_fault;
      end
      chk("fault_latency", 32'(n), 32'd17);
      chk("fault_busy", 32'(busy), 32'd0);
      chk("fault_pc", 32'(pc), 32'(pc_m));
      chk("fault_ir_kept", 32'({instr, operand}), 32'h42);
      @(posedge CLK); #1;
      chk("fault_one_cycle", 32'(fetch_fault), 32'd0);
    end
`endif

    repeat (2) @(posedge CLK);
    #1;
    chk("ir_valid_count", 32'(ir_seen), 32'(n_ir_exp));
    chk("reads_left", 32'(exp_addr_q.size()), 32'd0);
    chk("results_left", 32'(exp_ir_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion want finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, instruction word width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 5, operand/PC width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 15, memory-wait limit; used only under REQ-025.
REQ-004 Port CLK, input, 1: single clock, all state updates on rising edge.
REQ-005 Port RST_N, input, 1: reset, synchronous and active-low.
REQ-006 Port fetch, input, 1: fetch request from control unit, level, sampled in IDLE only.
REQ-007 Port pc_load, input, 1: jump strobe.
REQ-008 Port pc_load_val, input, ADDRESS_WIDTH: jump target.
REQ-009 Port mem_rd, output, 1: memory read request.
REQ-010 Port mem_addr, output, ADDRESS_WIDTH: read address.
REQ-011 Port mem_rdata, input, WORD_WIDTH: read data.
REQ-012 Port mem_ready, input, 1: read data valid.
REQ-013 Port instr, output, WORD_WIDTH-ADDRESS_WIDTH: opcode field (upper bits of IR).
REQ-014 Port operand, output, ADDRESS_WIDTH: address field (lower bits of IR).
REQ-015 Port pc, output, ADDRESS_WIDTH: current program counter.
REQ-016 Port ir_valid, output, 1: one-cycle pulse when IR is updated.
REQ-017 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, with transitions: IDLE->REQ on fetch; REQ->WAIT unconditionally; WAIT->IDLE on mem_ready; no other transitions.
REQ-019 mem_rd SHALL be high in REQ and WAIT only; mem_addr SHALL equal pc, held stable for the whole REQ/WAIT interval.
REQ-020 On the WAIT cycle with mem_ready high, IR SHALL capture mem_rdata, ir_valid SHALL pulse the following cycle, and pc SHALL become pc+1 modulo 2^ADDRESS_WIDTH (all-ones wraps to 0).
REQ-021 Minimum fetch latency SHALL be 3 cycles from fetch sampled to ir_valid when mem_ready is high on first WAIT cycle.
REQ-022 pc_load in IDLE SHALL set pc to pc_load_val next cycle; if fetch is high in the same cycle, the fetch SHALL use pc_load_val as address.
REQ-023 pc_load while busy SHALL be latched as pending; at completion pc SHALL take the pending value instead of pc+1; a later pc_load while busy SHALL overwrite the pending value.
REQ-024 fetch high while busy SHALL be ignored; instr/operand SHALL hold the last captured IR until the next capture.

Configuration
REQ-025 With FETCH_TIMEOUT_EN defined, a counter SHALL count WAIT cycles, and reaching TIMEOUT_CYCLES without mem_ready SHALL return to IDLE, leave IR and pc unchanged, suppress ir_valid, and pulse an extra output fetch_fault for one cycle; without FETCH_TIMEOUT_EN, WAIT SHALL be held indefinitely and no fetch_fault port SHALL exist.

Reset
REQ-026 RST_N low at a rising edge SHALL force state IDLE, pc=0, IR=0, pending jump cleared, mem_rd=0, ir_valid=0, busy=0, timeout counter=0, fetch_fault=0.
REQ-027 Reset mid-fetch SHALL abort the read with no IR update, and mem_ready arriving after reset SHALL be ignored.

Verification
REQ-028 Reset, then fetch with mem_rdata=8'hA7, mem_ready on first WAIT -> mem_addr=0, instr=3'b101, operand=5'h07, pc=1, ir_valid pulse 3 cycles after fetch.
REQ-029 pc_load_val=5'h1F with pc_load, then fetch -> mem_addr=5'h1F, and after completion pc=0 (wrap).
REQ-030 pc_load=1, val=5'h0A, during WAIT with mem_ready delayed 4 cycles -> after completion pc=5'h0A, not pc+1.
REQ-031 fetch pulses repeated while busy -> exactly one memory read and one ir_valid.
REQ-032 RST_N low during WAIT, then mem_ready -> IR stays 0, pc=0, no ir_valid.
REQ-033 With FETCH_TIMEOUT_EN, mem_ready never asserted -> fetch_fault pulse after 15 WAIT cycles, state IDLE, pc unchanged.
